// File: rtl/os_encoder_if.sv
// Request/TX bundle between an LTSSM-side requester and the ordered-set encoder.
interface os_encoder_if #(
  parameter int MAX_LANES = 16
);
  logic [2:0]             gen;
  logic [4:0]             numberOfLanes;
  logic [1:0]             osType;
  logic [7:0]             linkNum;
  logic                   linkPad;
  logic                   lanePad;
  logic [7:0]             nFts;
  logic [7:0]             rateId;
  logic [7:0]             trainCtrl;
  logic                   req;
  logic                   ack;
  logic                   txReady;
  logic                   outValid;
  logic [8*MAX_LANES-1:0] dataOut;
  logic [MAX_LANES-1:0]   dataK;
  logic                   blockStart;
  logic [1:0]             syncHeader;
  logic                   busy;
  logic                   done;

  // Requester / downstream side: issues requests and grants symbol acceptance.
  modport master (
    output gen, numberOfLanes, osType, linkNum, linkPad, lanePad,
           nFts, rateId, trainCtrl, req, txReady,
    input  ack, outValid, dataOut, dataK, blockStart, syncHeader, busy, done
  );

  // Encoder side.
  modport slave (
    input  gen, numberOfLanes, osType, linkNum, linkPad, lanePad,
           nFts, rateId, trainCtrl, req, txReady,
    output ack, outValid, dataOut, dataK, blockStart, syncHeader, busy, done
  );
endinterface

// File: rtl/os_encoder.sv
// Transmit-side PCIe ordered-set generator: TS1/TS2/SKP/EIEOS, lane-striped.
module os_encoder #(
  parameter int         MAX_LANES = 16,
  parameter logic [7:0] PAD_SYM   = 8'hF7
) (
  input logic         clk,
  input logic         reset,
  os_encoder_if.slave bus
);

  localparam logic [1:0] OS_TS1   = 2'd0;
  localparam logic [1:0] OS_TS2   = 2'd1;
  localparam logic [1:0] OS_SKP   = 2'd2;
  localparam logic [1:0] OS_EIEOS = 2'd3;

  typedef enum logic {IDLE, SEND} state_t;

  state_t     state_reg, state_next;
  logic [3:0] sym_idx_reg, sym_idx_next;
  logic       ack_reg, ack_next;
  logic       done_reg, done_next;
  logic       load;

  // Fields captured when a request is accepted.
  logic [2:0] gen_reg;
  logic [4:0] lanes_reg;
  logic [1:0] os_reg;
  logic [7:0] link_reg, nfts_reg, rate_id_reg, train_reg;
  logic       link_pad_reg, lane_pad_reg;

  logic [4:0] lanes_dec;
  logic       hi_gen;
  logic [3:0] last_idx;
  logic       is_last;
  logic       sending;

  logic [7:0] base_sym;
  logic       base_k;
  logic       lane_slot;
  logic [7:0] ts_fill;

  logic [8*MAX_LANES-1:0] data_out;
  logic [MAX_LANES-1:0]   data_k;

  assign hi_gen   = (gen_reg >= 3'd3);
  assign last_idx = (!hi_gen && os_reg == OS_SKP) ? 4'd3 : 4'd15;
  assign is_last  = (sym_idx_reg == last_idx);
  assign sending  = (state_reg == SEND);
  assign ts_fill  = (os_reg == OS_TS1) ? 8'h4A : 8'h45;

  // Unsupported widths collapse to a single lane.
  always_comb begin
    case (bus.numberOfLanes)
      5'd1, 5'd2, 5'd4, 5'd8, 5'd16: lanes_dec = bus.numberOfLanes;
      default:                        lanes_dec = 5'd1;
    endcase
  end

  // State, symbol index and one-cycle status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      sym_idx_reg <= 4'd0;
      ack_reg     <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sym_idx_reg <= sym_idx_next;
      ack_reg     <= ack_next;
      done_reg    <= done_next;
    end
  end

  // Capture the request fields on accept so in-flight sets are immune to input changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gen_reg      <= 3'd0;
      lanes_reg    <= 5'd0;
      os_reg       <= 2'd0;
      link_reg     <= 8'd0;
      nfts_reg     <= 8'd0;
      rate_id_reg  <= 8'd0;
      train_reg    <= 8'd0;
      link_pad_reg <= 1'b0;
      lane_pad_reg <= 1'b0;
    end else if (load) begin
      gen_reg      <= bus.gen;
      lanes_reg    <= lanes_dec;
      os_reg       <= bus.osType;
      link_reg     <= bus.linkNum;
      nfts_reg     <= bus.nFts;
      rate_id_reg  <= bus.rateId;
      train_reg    <= bus.trainCtrl;
      link_pad_reg <= bus.linkPad;
      lane_pad_reg <= bus.lanePad;
    end
  end

  // Next-state: accept in IDLE, advance on txReady, restart back-to-back on a last-symbol req.
  always_comb begin
    state_next   = state_reg;
    sym_idx_next = sym_idx_reg;
    ack_next     = 1'b0;
    done_next    = 1'b0;
    load         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.req) begin
          state_next   = SEND;
          sym_idx_next = 4'd0;
          ack_next     = 1'b1;
          load         = 1'b1;
        end
      end
      SEND: begin
        if (bus.txReady) begin
          if (is_last) begin
            done_next    = 1'b1;
            sym_idx_next = 4'd0;
            if (bus.req) begin
              ack_next = 1'b1;
              load     = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else begin
            sym_idx_next = sym_idx_reg + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Lane-common symbol for the current column; lane_slot marks the per-lane lane-number symbol.
  always_comb begin
    base_sym  = 8'h00;
    base_k    = 1'b0;
    lane_slot = 1'b0;
    case (os_reg)
      OS_TS1, OS_TS2: begin
        case (sym_idx_reg)
          4'd0: begin
            if (hi_gen) base_sym = (os_reg == OS_TS1) ? 8'h1E : 8'h2D;
            else begin
              base_sym = 8'hBC;
              base_k   = 1'b1;
            end
          end
          4'd1: begin
            base_sym = link_pad_reg ? PAD_SYM : link_reg;
            base_k   = link_pad_reg && !hi_gen;
          end
          4'd2: begin
            base_sym  = PAD_SYM;
            base_k    = lane_pad_reg && !hi_gen;
            lane_slot = !lane_pad_reg;
          end
          4'd3:    base_sym = nfts_reg;
          4'd4:    base_sym = rate_id_reg;
          4'd5:    base_sym = train_reg;
          default: base_sym = ts_fill;
        endcase
      end
      OS_SKP: begin
        if (hi_gen) begin
          if (sym_idx_reg < 4'd12)       base_sym = 8'hAA;
          else if (sym_idx_reg == 4'd12) base_sym = 8'hE1;
          else                           base_sym = 8'h00;
        end else begin
          base_sym = (sym_idx_reg == 4'd0) ? 8'hBC : 8'h1C;
          base_k   = 1'b1;
        end
      end
      default: begin
        if (hi_gen) base_sym = sym_idx_reg[0] ? 8'hFF : 8'h00;
        else if (sym_idx_reg == 4'd0) begin
          base_sym = 8'hBC;
          base_k   = 1'b1;
        end else if (sym_idx_reg == 4'd15) base_sym = 8'h4A;
        else begin
          base_sym = 8'hFC;
          base_k   = 1'b1;
        end
      end
    endcase
  end

  // Stripe the column across active lanes; inactive lanes and idle state drive zero.
  for (genvar gi = 0; gi < MAX_LANES; gi++) begin : g_lane
    logic lane_on;
    assign lane_on = sending && (gi < int'(lanes_reg));
    assign data_out[8*gi +: 8] = !lane_on ? 8'h00 : (lane_slot ? 8'(gi) : base_sym);
    assign data_k[gi]          = lane_on && base_k;
  end

  assign bus.dataOut    = data_out;
  assign bus.dataK      = data_k;
  assign bus.outValid   = sending;
  assign bus.busy       = sending;
  assign bus.ack        = ack_reg;
  assign bus.done       = done_reg;
  assign bus.blockStart = sending && (sym_idx_reg == 4'd0);
  assign bus.syncHeader = (sending && sym_idx_reg == 4'd0 && hi_gen) ? 2'b01 : 2'b00;

endmodule

// File: tb/tb_os_encoder.sv
// Scoreboard bench for os_encoder: model builds whole sets from the rules, monitor compares per column.
module tb_os_encoder;
  localparam int ML = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  os_encoder_if #(.MAX_LANES(ML)) bus ();

  os_encoder #(.MAX_LANES(ML), .PAD_SYM(8'hF7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [8*ML-1:0] data;
    logic [ML-1:0]   k;
    logic            bs;
    logic [1:0]      sh;
    logic            last;
  } col_t;

  col_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   ack_exp = 1'b0;
  bit   done_exp = 1'b0;
  bit   idle_m;
  bit   acc_last;
  int   tx_mode = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference model: lay out the full symbol sequence of the requested set, then stripe it.
  task automatic push_set();
    int          g     = int'(bus.gen);
    int          nl    = int'(bus.numberOfLanes);
    int          os    = int'(bus.osType);
    bit          hi    = (g >= 3);
    bit          ts    = (os < 2);
    int          lanes = (nl == 1 || nl == 2 || nl == 4 || nl == 8 || nl == 16) ? nl : 1;
    logic [7:0]  fill  = (os == 0) ? 8'h4A : 8'h45;
    logic [7:0]  s[$];
    bit          kk[$];
    col_t        c;
    case (os)
      0, 1: begin
        s.push_back(hi ? ((os == 0) ? 8'h1E : 8'h2D) : 8'hBC); kk.push_back(!hi);
        s.push_back(bus.linkPad ? 8'hF7 : bus.linkNum);         kk.push_back(bus.linkPad && !hi);
        s.push_back(8'hF7);                                     kk.push_back(bus.lanePad && !hi);
        s.push_back(bus.nFts);                                  kk.push_back(1'b0);
        s.push_back(bus.rateId);                                kk.push_back(1'b0);
        s.push_back(bus.trainCtrl);                             kk.push_back(1'b0);
        repeat (10) begin s.push_back(fill); kk.push_back(1'b0); end
      end
      2: begin
        if (hi) begin
          repeat (12) begin s.push_back(8'hAA); kk.push_back(1'b0); end
          s.push_back(8'hE1); kk.push_back(1'b0);
          repeat (3) begin s.push_back(8'h00); kk.push_back(1'b0); end
        end else begin
          s.push_back(8'hBC); kk.push_back(1'b1);
          repeat (3) begin s.push_back(8'h1C); kk.push_back(1'b1); end
        end
      end
      default: begin
        for (int i = 0; i < 16; i++) begin
          if (hi) begin s.push_back((i % 2) ? 8'hFF : 8'h00); kk.push_back(1'b0); end
          else if (i == 0)  begin s.push_back(8'hBC); kk.push_back(1'b1); end
          else if (i == 15) begin s.push_back(8'h4A); kk.push_back(1'b0); end
          else              begin s.push_back(8'hFC); kk.push_back(1'b1); end
        end
      end
    endcase
    for (int i = 0; i < s.size(); i++) begin
      c = '0;
      for (int n = 0; n < lanes; n++) begin
        c.data[8*n +: 8] = (ts && i == 2 && !bus.lanePad) ? 8'(n) : s[i];
        c.k[n]           = (ts && i == 2 && !bus.lanePad) ? 1'b0 : kk[i];
      end
      c.bs   = (i == 0);
      c.sh   = (i == 0 && hi) ? 2'b01 : 2'b00;
      c.last = (i == s.size() - 1);
      exp_q.push_back(c);
    end
  endtask

  // Monitor: compare every column away from the clock edge, then advance the model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("reset_ctrl", {bus.outValid, bus.busy, bus.ack, bus.done, bus.blockStart,
                         bus.syncHeader, bus.dataK}, '0);
      chk("reset_data", bus.dataOut, '0);
      exp_q.delete();
      ack_exp  = 1'b0;
      done_exp = 1'b0;
    end else begin
      idle_m = (exp_q.size() == 0);
      chk("outValid", bus.outValid, !idle_m);
      chk("busy", bus.busy, !idle_m);
      chk("ack", bus.ack, ack_exp);
      chk("done", bus.done, done_exp);
      if (!idle_m) begin
        chk("dataOut", bus.dataOut, exp_q[0].data);
        chk("dataK", bus.dataK, exp_q[0].k);
        chk("blockStart", bus.blockStart, exp_q[0].bs);
        chk("syncHeader", bus.syncHeader, exp_q[0].sh);
      end else begin
        chk("idle_out", {bus.dataK, bus.blockStart, bus.syncHeader}, '0);
        chk("idle_data", bus.dataOut, '0);
      end
      acc_last = !idle_m && bus.txReady && exp_q[0].last;
      ack_exp  = bus.req && (idle_m || acc_last);
      done_exp = acc_last;
      if (!idle_m && bus.txReady) void'(exp_q.pop_front());
      if (ack_exp) push_set();
    end
  end

  // Downstream acceptance pattern: always, 1-0-0 repeating, or random.
  always @(posedge clk) begin
    #1;
    case (tx_mode)
      0:       bus.txReady = 1'b1;
      1:       bus.txReady = (cyc % 3 == 0);
      default: bus.txReady = 1'($urandom_range(0, 1));
    endcase
    cyc++;
  end

  task automatic set_fields(input int g, input int nl, input int os, input int link,
                            input bit lp, input bit lnp, input int nf, input int rid, input int tc);
    bus.gen = 3'(g); bus.numberOfLanes = 5'(nl); bus.osType = 2'(os);
    bus.linkNum = 8'(link); bus.linkPad = lp; bus.lanePad = lnp;
    bus.nFts = 8'(nf); bus.rateId = 8'(rid); bus.trainCtrl = 8'(tc);
  endtask

  task automatic scramble();
    set_fields($urandom_range(1, 5), $urandom_range(0, 31), $urandom_range(0, 3), $urandom,
               1'($urandom), 1'($urandom), $urandom, $urandom, $urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.done) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done within %0d cycles, required done pulse", n);
    end
  endtask

  // One request; fields are scrambled after accept to prove they were latched.
  task automatic run_set();
    bus.req = 1'b1;
    @(posedge clk); #1;
    bus.req = 1'b0;
    scramble();
    wait_done();
    $display("set done at t=%0t checks=%0d errors=%0d", $time, checks, errors);
  endtask

  // req held across two sets: the second accept lands on the first set's last symbol.
  task automatic run_b2b();
    int acks = 0;
    int n = 0;
    bus.req = 1'b1;
    while (acks < 2 && n < 300) begin
      @(posedge clk); #1; n++;
      if (bus.ack) acks++;
    end
    bus.req = 1'b0;
    if (acks < 2) begin
      checks++; errors++;
      $display("FAIL b2b_ack_timeout: got %0d acks, required 2", acks);
    end
    @(posedge clk); #1;
    wait_done();
    $display("b2b pair done at t=%0t checks=%0d errors=%0d", $time, checks, errors);
  endtask

  initial begin
    bus.req = 1'b0;
    set_fields(1, 2, 0, 8'h05, 0, 0, 8'h20, 8'h06, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk); #1;

    tx_mode = 0; set_fields(1, 2, 0, 8'h05, 0, 0, 8'h20, 8'h06, 0); run_set();
    tx_mode = 0; set_fields(2, 4, 2, 8'h00, 0, 0, 0, 0, 0);         run_set();
    tx_mode = 0; set_fields(3, 8, 1, 8'h11, 1, 1, 8'h30, 8'h1F, 0); run_set();
    tx_mode = 1; set_fields(1, 2, 0, 8'h05, 0, 0, 8'h20, 8'h06, 0); run_set();
    tx_mode = 0; set_fields(3, 16, 3, 0, 0, 0, 0, 0, 0);            run_b2b();

    // Reset pulse while column 7 of a Gen1 TS1 is on the bus.
    tx_mode = 0; set_fields(1, 2, 0, 8'h05, 0, 0, 8'h20, 8'h06, 0);
    bus.req = 1'b1;
    @(posedge clk); #1;
    bus.req = 1'b0;
    repeat (7) @(posedge clk);
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    set_fields(1, 2, 0, 8'h05, 0, 0, 8'h20, 8'h06, 0); run_set();

    // Randomized sets, including invalid lane counts and stalls.
    for (int i = 0; i < 24; i++) begin
      tx_mode = $urandom_range(0, 2);
      scramble();
      if (i % 6 == 5) run_b2b();
      else            run_set();
    end

    repeat (3) @(posedge clk); #1;
    chk("queue_empty", 128'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
